// File: rtl/load_store_unit.sv
// load_store_unit: turns CPU byte/half/word load and store requests into
// word-aligned memory reads and writes. Sub-word stores go through a
// read-modify-write; loads are lane-extracted and sign/zero extended.
// Misaligned or illegal requests are answered without touching memory.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only while the unit is idle (and not held in reset), so at
// most one access is in flight. The requester must keep req_* stable until that
// edge. Completion is a single-cycle resp_valid pulse with no back-pressure.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_old;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_mis;

  logic              w_accept;
  logic              w_req_mis;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merge;

  assign w_accept = req_valid && req_ready;

  // Alignment/legality of the incoming request, evaluated only at accept.
  assign w_req_mis = (req_size == 2'b11) ||
                     ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  // Handshake and memory-side outputs depend only on state and captured fields.
  assign req_ready       = (r_state == IDLE) && !reset;
  assign resp_valid      = (r_state == RESP);
  assign resp_rdata      = r_resp_rdata;
  assign resp_misaligned = r_resp_mis;
  assign mem_address     = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_read        = (r_state == READ);
  assign mem_write       = (r_state == WRITE);
  assign mem_write_data  = (r_state == WRITE) ? w_merge : '0;
  assign dbg_state       = r_state;

  // Load path: pick the addressed lane from the memory word and extend it.
  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0: w_byte = mem_read_data[7:0];
      2'd1: w_byte = mem_read_data[15:8];
      2'd2: w_byte = mem_read_data[23:16];
      default: w_byte = mem_read_data[31:24];
    endcase
    w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    w_load = mem_read_data;
    case (r_size)
      SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_read_data;
    endcase
  end

  // Store path: overlay the store lane(s) on the previously read word.
  always_comb begin
    w_merge = r_old;
    case (r_size)
      SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0: w_merge[7:0]   = r_wdata[7:0];
          2'd1: w_merge[15:8]  = r_wdata[7:0];
          2'd2: w_merge[23:16] = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  // Control FSM plus request capture and registered response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_old        <= '0;
      r_resp_rdata <= '0;
      r_resp_mis   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_write  <= req_write;
            r_wdata  <= req_wdata;
            if (w_req_mis) begin
              r_state      <= RESP;
              r_resp_rdata <= '0;
              r_resp_mis   <= 1'b1;
            end else if (req_write && (req_size == SZ_WORD)) begin
              r_state <= WRITE;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          r_old <= mem_read_data;
          if (r_write) begin
            r_state <= WRITE;
          end else begin
            r_state      <= RESP;
            r_resp_rdata <= w_load;
            r_resp_mis   <= 1'b0;
          end
        end
        WRITE: begin
          r_state      <= RESP;
          r_resp_rdata <= '0;
          r_resp_mis   <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_resp_rdata <= '0;
          r_resp_mis   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests, a byte-level memory model that
// predicts every memory cycle and response, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_load_store_unit;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic [1:0]  dbg_state;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .dbg_state(dbg_state)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [31:0] bmem [0:255];
  assign mem_read_data = mem_read ? bmem[mem_address[9:2]] : 32'h0;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
    if (mem_write) bmem[mem_address[9:2]] <= mem_write_data;
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        mis;
  } ev_t;
  typedef ev_t ev_q_t[$];

  ev_t         resp_q[$];
  ev_t         rd_q[$];
  ev_t         wr_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  ref_bytes [0:1023];
  logic [7:0]  ref_prev  [0:1023];
  int          busy_start = 0;
  int          ready_from = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_mis = 1'b0;
  int          resp_cycles[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    check(name, {31'b0, act}, {31'b0, req});
  endtask

  function automatic ev_q_t keep_upto(input ev_q_t q, input int c);
    ev_q_t t;
    t = {};
    foreach (q[i]) if (q[i].cyc <= c) t.push_back(q[i]);
    return t;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'({a[9:2], 2'b00});
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  // Load value as an integer assembled from bytes, then two's-complement adjusted.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = 64'h0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_bytes[int'(a[9:0]) + i]) << (8 * i));
    if (sg && sz != 2'b10 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    bmem[a[9:2]] = w;
    for (int i = 0; i < 4; i++) ref_bytes[int'({a[9:2], 2'b00}) + i] = w[8*i +: 8];
  endtask

  // Predict everything the accepted request must cause, given accept edge k.
  task automatic model_push(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, input int k);
    logic mis;
    int   lat;
    int   n;
    ev_t  e;
    ref_prev = ref_bytes;
    mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    if (mis)                lat = 1;
    else if (!w)            lat = 2;
    else if (sz == 2'b10)   lat = 2;
    else                    lat = 3;
    e.addr = {a[31:2], 2'b00};
    e.mis  = 1'b0;
    if (mis) begin
      e.cyc = k; e.data = 32'h0; e.mis = 1'b1;
      resp_q.push_back(e); exp_q.push_back(32'h0);
    end else if (!w) begin
      e.cyc = k; e.data = 32'h0; rd_q.push_back(e);
      e.cyc = k + 1; e.data = model_load(a, sz, sg);
      resp_q.push_back(e); exp_q.push_back(e.data);
    end else begin
      n = 1 << sz;
      for (int i = 0; i < n; i++) ref_bytes[int'(a[9:0]) + i] = wd[8*i +: 8];
      if (sz != 2'b10) begin e.cyc = k; e.data = 32'h0; rd_q.push_back(e); end
      e.cyc = k + lat - 2; e.data = ref_word(a); wr_q.push_back(e);
      e.cyc = k + lat - 1; e.data = 32'h0;
      resp_q.push_back(e); exp_q.push_back(32'h0);
    end
    busy_start = k;
    ready_from = k + lat;
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int waited;
    waited = 0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      check1("accept_timeout", req_ready, 1'b1);
    end else begin
      model_push(w, sz, sg, a, wd, cyc + 1);
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    req_valid = 1'b0;
    while ((resp_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0 || cyc < ready_from)
           && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check("drain_pending", 32'(resp_q.size() + rd_q.size() + wr_q.size()), 32'd0);
  endtask

  task automatic op(input logic w, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd);
    issue(w, sz, sg, a, wd);
    drain();
  endtask

  // ---------------- per-cycle compare process ----------------
  task automatic monitor_cycle();
    logic exp_ready;
    logic exp_resp;
    logic exp_rd;
    logic exp_wr;
    exp_ready = !reset && !(cyc >= busy_start && cyc < ready_from);
    check1("req_ready", req_ready, exp_ready);
    check("mem_addr_align", {30'b0, mem_address[1:0]}, 32'h0);
    check1("rd_wr_exclusive", mem_read & mem_write, 1'b0);
    if (rst_seen) begin
      check("reset_ctrl", {28'b0, resp_valid, resp_misaligned, mem_read, mem_write}, 32'h0);
      check("reset_rdata", resp_rdata, 32'h0);
      check("reset_mem_address", mem_address, 32'h0);
      check("reset_mem_wdata", mem_write_data, 32'h0);
    end
    exp_resp = resp_q.size() > 0 && resp_q[0].cyc == cyc;
    if (exp_resp || resp_valid) begin
      check1("resp_valid", resp_valid, exp_resp);
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_mis   = resp_misaligned;
        resp_cycles.push_back(cyc);
      end
      if (exp_resp) begin
        check("resp_rdata", resp_rdata, exp_q[0]);
        check1("resp_misaligned", resp_misaligned, resp_q[0].mis);
        resp_q.pop_front();
        exp_q.pop_front();
      end
    end else begin
      check("resp_idle_zero", resp_rdata | {31'b0, resp_misaligned}, 32'h0);
    end
    exp_rd = rd_q.size() > 0 && rd_q[0].cyc == cyc;
    if (exp_rd || mem_read) begin
      check1("mem_read", mem_read, exp_rd);
      if (exp_rd) begin
        check("mem_read_addr", mem_address, rd_q[0].addr);
        rd_q.pop_front();
      end
    end
    exp_wr = wr_q.size() > 0 && wr_q[0].cyc == cyc;
    if (exp_wr || mem_write) begin
      check1("mem_write", mem_write, exp_wr);
      if (exp_wr) begin
        check("mem_write_addr", mem_address, wr_q[0].addr);
        check("mem_write_data", mem_write_data, wr_q[0].data);
        wr_q.pop_front();
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (cyc >= 1) monitor_cycle();
    end
  end

  // ---------------- main sequence ----------------
  int rc_base;

  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;
    preload(32'h00, 32'h01020304);
    preload(32'h04, 32'h80FF7F01);
    preload(32'h0C, 32'h0A0B0C0D);
    preload(32'h10, 32'h11223344);
    preload(32'h20, 32'hCAFEF00D);

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // word store then word load
    op(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
    check("sw_mem_word", bmem[2], 32'hDEADBEEF);
    op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    check("lw_rdata", last_rdata, 32'hDEADBEEF);

    // byte and half read-modify-write
    op(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAA);
    check("sb_mem_word", bmem[4], 32'h11AA3344);
    op(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
    check("sh_mem_word", bmem[4], 32'hBEEF3344);
    op(1'b1, 2'b00, 1'b0, 32'h0F, 32'h00000099);
    check("sb_lane3_word", bmem[3], 32'h990B0C0D);

    // signed and unsigned sub-word loads
    op(1'b0, 2'b00, 1'b1, 32'h06, 32'h0);
    check("lb_rdata", last_rdata, 32'hFFFFFFFF);
    op(1'b0, 2'b00, 1'b0, 32'h06, 32'h0);
    check("lbu_rdata", last_rdata, 32'h000000FF);
    op(1'b0, 2'b01, 1'b1, 32'h06, 32'h0);
    check("lh_rdata", last_rdata, 32'hFFFF80FF);
    op(1'b0, 2'b01, 1'b0, 32'h04, 32'h0);
    check("lhu_rdata", last_rdata, 32'h00007F01);
    op(1'b0, 2'b01, 1'b1, 32'h04, 32'h0);
    check("lh_pos_rdata", last_rdata, 32'h00007F01);
    op(1'b0, 2'b00, 1'b1, 32'h05, 32'h0);
    check("lb_pos_rdata", last_rdata, 32'h0000007F);
    op(1'b0, 2'b10, 1'b1, 32'h04, 32'h0);
    check("lw_signed_ignored", last_rdata, 32'h80FF7F01);

    // misaligned and illegal accesses
    op(1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    check1("lw_mis_flag", last_mis, 1'b1);
    op(1'b0, 2'b01, 1'b1, 32'h03, 32'h0);
    check1("lh_mis_flag", last_mis, 1'b1);
    op(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    check1("size3_mis_flag", last_mis, 1'b1);
    op(1'b1, 2'b10, 1'b0, 32'h05, 32'h55555555);
    op(1'b1, 2'b01, 1'b0, 32'h01, 32'h00006666);
    check("mis_store_untouched", bmem[0], 32'h01020304);
    check("mis_store_untouched1", bmem[1], 32'h80FF7F01);

    // back-to-back loads with req_valid held high
    rc_base = resp_cycles.size();
    issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    drain();
    check("b2b_resp_count", 32'(resp_cycles.size() - rc_base), 32'd4);
    if (resp_cycles.size() - rc_base == 4) begin
      for (int i = 1; i < 4; i++)
        check("b2b_gap", 32'(resp_cycles[rc_base+i] - resp_cycles[rc_base+i-1]), 32'd3);
    end
    check("b2b_last_rdata", last_rdata, 32'h990B0C0D);

    // reset while a byte store sits in its READ cycle
    rc_base = resp_cycles.size();
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055);
    req_valid = 1'b0;
    reset = 1'b1;
    resp_q = keep_upto(resp_q, cyc);
    rd_q   = keep_upto(rd_q, cyc);
    wr_q   = keep_upto(wr_q, cyc);
    exp_q  = {};
    foreach (resp_q[i]) exp_q.push_back(resp_q[i].data);
    ref_bytes  = ref_prev;
    busy_start = 0;
    ready_from = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_no_resp", 32'(resp_cycles.size() - rc_base), 32'd0);
    check("rst_word_unchanged", bmem[8], 32'hCAFEF00D);
    op(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    check("post_rst_lbu", last_rdata, 32'h000000F0);

    // whole touched region against the byte model
    for (int wi = 0; wi < 16; wi++)
      check("mem_final", bmem[wi], ref_word(32'(wi * 4)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits directly upstream of the word-addressed data memory. It converts CPU load/store requests (byte, halfword, word; signed/unsigned loads) into word-aligned memory reads and writes. Sub-word stores use a read-modify-write sequence. Loads are byte/half extracted and sign/zero extended. Misaligned or illegal accesses are flagged and never reach memory.

Parameters:
ADDR_W, 32, request/memory address width
DATA_W, 32, data width; only 32 is supported

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend load result (byte/half only)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_misaligned  out  1  valid with resp_valid; access rejected
mem_address  out  32  word-aligned byte address to memory
mem_write_data  out  32  word to memory
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
mem_read_data  in  32  memory read word (combinational from mem_address/mem_read)

Behaviour:
- States: IDLE, READ, WRITE, RESP. Reset -> IDLE.
- Reset values: all outputs 0; req_ready goes to 1 on the first cycle after reset deasserts.
- req_ready = (state == IDLE). A request is accepted at an edge where req_valid && req_ready.
- On accept, capture addr, size, signed, write, and wdata into registers.
- Memory-side outputs are decoded only from state and captured registers. There is no combinational path from req_* to mem_*.
- mem_address = {addr_q[31:2], 2'b00}. It is held stable for the whole READ/WRITE cycle.
- mem_read is high only in READ. mem_write is high only in WRITE, for exactly one cycle. They are never high together.
- Misalignment check at accept:
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0] != 0 is misaligned;
  - size 11 is illegal.
  - Any of these -> RESP directly. No mem_read or mem_write. resp_misaligned = 1, resp_rdata = 0.
- Transitions from IDLE on accept:
  - load -> READ -> RESP;
  - word store -> WRITE -> RESP;
  - byte/half store -> READ -> WRITE -> RESP;
  - error -> RESP.
- Latency, with the request accepted at edge k and resp_valid high in cycle:
  - error: k+1;
  - load: k+2;
  - word store: k+2;
  - sub-word store: k+3.
- READ: mem_read_data is captured into old_q at the end of the cycle.
- Byte lanes are little-endian. Byte lane = addr[1:0]; lane 0 = bits 7:0. Half at addr[1]=0 is bits 15:0; at addr[1]=1 it is bits 31:16.
- Store merge: WRITE data = old_q with the selected lane(s) replaced by wdata_q[7:0] or [15:0]. A word store writes wdata_q unchanged.
- Load extract: the selected lane is sign-extended if signed_q, else zero-extended. Word loads ignore signed_q.
- RESP: resp_valid = 1 for one cycle, then IDLE. resp_rdata and resp_misaligned are registered and valid only while resp_valid is high. They return to 0 in IDLE.
- Back-to-back: a new request may be accepted in the IDLE cycle right after RESP. Minimum spacing is request-to-request = latency + 1.
- req_* changes while busy are ignored (captured values only).
- Reset mid-operation:
  - takes effect at the next edge and returns to IDLE;
  - no resp_valid for the aborted access;
  - a WRITE cycle in progress during the reset cycle still completes, because memory is level-sensitive;
  - a pending RMW whose WRITE has not started is dropped, and memory is unchanged.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x8, then lw @0x8 -> mem_write exactly 1 cycle with mem_address=0x8; resp_rdata=0xDEADBEEF at k+2.
- Byte RMW: word@0x10=0x11223344, sb 0xAA @0x12 -> READ then WRITE with mem_write_data=0x11AA3344; resp at k+3.
- Signed/unsigned loads: word@0x4=0x80FF7F01. lb @0x6 -> 0xFFFFFFFF; lbu @0x6 -> 0x000000FF; lh @0x6 -> 0xFFFF80FF; lhu @0x4 -> 0x00007F01.
- Misaligned: lw @0x2, lh @0x3, size 11 @0x0 -> resp at k+1 with resp_misaligned=1, resp_rdata=0; mem_read/mem_write never asserted; memory unchanged.
- Back-to-back with req_valid held high: 4 loads at 0x0/0x4/0x8/0xC -> req_ready low while busy; responses in order, 3 cycles apart.
- Reset after a sub-word store's READ cycle (before WRITE) -> IDLE next edge, no resp_valid, target word unchanged, req_ready=1 after reset drops.
